if_id_skid_stage: RTL



---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_entry_reg.sv | 26 ++
 rtl/if_id_skid_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline stages: the NOP encoding,
// the stage state encoding and the width of the {pc, instr} bundle.
package pipe_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned INSTR_W = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } stage_state_e;

    function automatic int unsigned entry_width(int unsigned xlen);
        return xlen + INSTR_W;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Load-enabled {pc, instr} entry register with asynchronous active-high reset
// and a parameterised reset value.
module pipe_entry_reg #(
    parameter int unsigned       Width    = 64,
    parameter logic [Width-1:0]  ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= ResetVal;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// Fetch-to-decode stage: valid/ready handshake with a 2-entry skid buffer and
// registered in_ready. Optional stall counter enabled by IF_ID_STALL_COUNT_EN.
module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
`ifdef IF_ID_STALL_COUNT_EN
    ,
    output logic [15:0]     stall_count
`endif
);

    localparam int unsigned EntryW = entry_width(XLEN);
    localparam logic [EntryW-1:0] MainResetVal = {{XLEN{1'b0}}, NOP_INSTR};

    stage_state_e state_q, state_d;
    logic         in_ready_q;
    logic         in_fire, out_fire;
    logic         main_load, skid_load;
    logic [EntryW-1:0] in_entry, main_d, main_q, skid_q;

    assign in_entry  = {in_pc, in_instr};
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;
    assign out_valid = (state_q != StEmpty);
    assign in_ready  = in_ready_q;
    assign out_pc    = main_q[EntryW-1 -: XLEN];
    assign out_instr = main_q[INSTR_W-1:0];

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_entry;
        if (flush) begin
            // Keep the PC for debug visibility, but never leave a real instruction behind.
            state_d   = StEmpty;
            main_load = 1'b1;
            main_d    = {out_pc, NOP_INSTR};
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_d   = StFull;
                    end
                end
                StFull: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = StSkid;
                    end else if (out_fire) begin
                        state_d   = StEmpty;
                    end
                end
                StSkid: begin
                    if (out_fire) begin
                        main_load = 1'b1;
                        main_d    = skid_q;
                        state_d   = StFull;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // in_ready is a flop of the next state, so there is no path from out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StSkid);
        end
    end

    pipe_entry_reg #(
        .Width    (EntryW),
        .ResetVal (MainResetVal)
    ) u_main (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_entry_reg #(
        .Width    (EntryW),
        .ResetVal ('0)
    ) u_skid (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (skid_load),
        .d_i    (in_entry),
        .q_o    (skid_q)
    );

`ifdef IF_ID_STALL_COUNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule
